// File: rtl/bit_serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and counter sizing.
package bit_serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;

    // Bit counter only needs to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/bit_serial_adder_fa.sv
// One-bit structural full-adder cell.
module bit_serial_adder_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_co
);

    assign o_s  = i_a ^ i_b ^ i_c;
    assign o_co = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder: one full-adder cell, registered carry, one bit per clock.
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT
);

    localparam int             CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-2:0] r_res_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CNT_W-1:0] r_cnt;
    logic             w_sum_bit;
    logic             w_carry_nxt;
    logic             w_last;
    logic             w_load;
    logic [WIDTH-1:0] w_res_nxt;

    bit_serial_adder_fa u_fa (
        .i_a  (r_a_sh[0]),
        .i_b  (r_b_sh[0]),
        .i_c  (r_carry),
        .o_s  (w_sum_bit),
        .o_co (w_carry_nxt)
    );

    assign w_last    = (r_cnt == CNT_LAST);
    // Only the upper WIDTH-1 result bits are kept; the final shift lands straight in r_sum.
    assign w_res_nxt = {w_sum_bit, r_res_sh};

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (START) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state  <= S_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_a_sh  <= A;
                r_b_sh  <= B;
                r_carry <= CIN;
                r_cnt   <= '0;
            end else if (r_state == S_RUN) begin
                r_a_sh   <= r_a_sh >> 1;
                r_b_sh   <= r_b_sh >> 1;
                r_carry  <= w_carry_nxt;
                r_res_sh <= w_res_nxt[WIDTH-1:1];
                if (w_last) begin
                    r_sum  <= w_res_nxt;
                    r_cout <= w_carry_nxt;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign BUSY = (r_state == S_RUN);
    assign DONE = (r_state == S_DONE);
    assign SUM  = r_sum;
    assign COUT = r_cout;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and swept checks of bit_serial_adder at WIDTH=8 and WIDTH=16.
module tb_bit_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start8, cin8, busy8, done8, cout8;
    logic [7:0]  a8, b8, sum8;
    logic        start16, cin16, busy16, done16, cout16;
    logic [15:0] a16, b16, sum16;

    int          n_vec = 0;
    int          n_err = 0;
    logic [8:0]  prev8;
    logic [16:0] prev16;

    always #5 clk = ~clk;

    bit_serial_adder #(.WIDTH(8)) u_dut8 (
        .CLK(clk), .RST_N(rst_n), .START(start8), .A(a8), .B(b8), .CIN(cin8),
        .BUSY(busy8), .DONE(done8), .SUM(sum8), .COUT(cout8)
    );

    bit_serial_adder #(.WIDTH(16)) u_dut16 (
        .CLK(clk), .RST_N(rst_n), .START(start16), .A(a16), .B(b16), .CIN(cin16),
        .BUSY(busy16), .DONE(done16), .SUM(sum16), .COUT(cout16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One operation on the 8-bit DUT; operands are scrambled after capture.
    task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        output int lat, output int bsy, output int held);
        @(negedge clk);
        a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
        @(posedge clk);
        lat = 0; bsy = 0; held = 1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start8 = 1'b0; a8 = ~ia; b8 = ib ^ 8'h5A; cin8 = ~ic;
            end
            if (done8) begin
                lat = i;
                break;
            end
            if (busy8) bsy++;
            if ({cout8, sum8} !== prev8) held = 0;
        end
    endtask

    task automatic op8(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                       input logic ic, input logic [8:0] exp, input bit full);
        int lat, bsy, held;
        run8(ia, ib, ic, lat, bsy, held);
        chk({tag, "_res"}, 64'({cout8, sum8}), 64'(exp));
        if (full) begin
            chk({tag, "_lat"}, 64'(lat), 64'd9);
            chk({tag, "_busy"}, 64'(bsy), 64'd8);
            chk({tag, "_hold"}, 64'(held), 64'd1);
            @(negedge clk);
            chk({tag, "_pulse"}, 64'(done8), 64'd0);
        end
        prev8 = exp;
    endtask

    task automatic op16(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                        input logic ic, input bit full);
        int lat = 0, bsy = 0, held = 1;
        logic [16:0] exp;
        exp = 17'(ia) + 17'(ib) + 17'(ic);
        @(negedge clk);
        a16 = ia; b16 = ib; cin16 = ic; start16 = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start16 = 1'b0; a16 = ~ia; b16 = ~ib;
            end
            if (done16) begin
                lat = i;
                break;
            end
            if (busy16) bsy++;
            if ({cout16, sum16} !== prev16) held = 0;
        end
        chk({tag, "_res"}, 64'({cout16, sum16}), 64'(exp));
        chk({tag, "_hold"}, 64'(held), 64'd1);
        if (full) begin
            chk({tag, "_lat"}, 64'(lat), 64'd17);
            chk({tag, "_busy"}, 64'(bsy), 64'd16);
        end
        prev16 = exp;
    endtask

    initial begin
        int lat, dn, cyc, last, j, blow;
        logic [8:0] snap;
        logic [7:0] ra, rb;
        logic       rc;
        logic [7:0] ba [4] = '{8'h01, 8'h7F, 8'h80, 8'hAA};
        logic [7:0] bb [4] = '{8'h02, 8'h01, 8'h80, 8'h55};
        logic       bc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [8:0] be [4] = '{9'h003, 9'h080, 9'h100, 9'h100};

        rst_n = 1'b0; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
        prev8 = '0; prev16 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy8), 64'd0);
        chk("rst_done", 64'(done8), 64'd0);
        chk("rst_sum", 64'({cout8, sum8}), 64'd0);
        chk("rst_sum16", 64'({busy16, done16, cout16, sum16}), 64'd0);
        rst_n = 1'b1;

        op8("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 9'h096, 1'b1);
        op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 9'h100, 1'b1);
        op8("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b1);
        op8("add_00_00_c", 8'h00, 8'h00, 1'b1, 9'h001, 1'b1);

        // START pulsed during RUN cycle 3 must be ignored.
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        lat = 0; dn = 0; snap = '0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) start8 = 1'b0;
            if (i == 3) begin start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; end
            if (i == 4) start8 = 1'b0;
            if (done8) begin
                dn++;
                if (lat == 0) begin lat = i; snap = {cout8, sum8}; end
            end
        end
        chk("ign_res", 64'(snap), 64'h030);
        chk("ign_lat", 64'(lat), 64'd9);
        chk("ign_ndone", 64'(dn), 64'd1);
        prev8 = 9'h030;

        // Back-to-back with START held high.
        @(negedge clk);
        a8 = ba[0]; b8 = bb[0]; cin8 = bc[0]; start8 = 1'b1;
        @(posedge clk);
        j = 0; last = 0; blow = 0;
        for (cyc = 1; cyc <= 80 && j < 4; cyc++) begin
            @(negedge clk);
            if (done8) begin
                chk("b2b_res", 64'({cout8, sum8}), 64'(be[j]));
                chk("b2b_gap", 64'(cyc - last), 64'd9);
                chk("b2b_busy_in_done", 64'(busy8), 64'd0);
                last = cyc;
                j++;
                if (j < 4) begin
                    a8 = ba[j]; b8 = bb[j]; cin8 = bc[j];
                end else begin
                    start8 = 1'b0;
                end
            end else if (!busy8) begin
                blow++;
            end
        end
        chk("b2b_count", 64'(j), 64'd4);
        chk("b2b_busy_gaps", 64'(blow), 64'd0);
        prev8 = 9'h100;

        // Synchronous reset during RUN cycle 4.
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_busy", 64'(busy8), 64'd0);
        chk("mrst_done", 64'(done8), 64'd0);
        chk("mrst_res", 64'({cout8, sum8}), 64'd0);
        dn = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8) dn++;
        end
        chk("mrst_nodone", 64'(dn), 64'd0);
        prev8 = '0;
        op8("post_rst", 8'h01, 8'h01, 1'b0, 9'h002, 1'b1);

        for (int k = 0; k < 1000; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            op8("sweep8", ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc), 1'b0);
        end

        op16("add16_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        op16("add16_8000_c", 16'h8000, 16'h8000, 1'b1, 1'b1);
        for (int k = 0; k < 200; k++) begin
            op16("sweep16", 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
